// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the three sides of the SRAM arbiter: the instruction-fetch port,
//   the MEM-stage data port and the board SRAM pins.
//   modport slave  : the arbiter (consumes requests and SRAM read data,
//                    drives ready/data back and all SRAM control pins)
//   modport master : the surroundings (CPU ports plus the SRAM device)
//   Fetch   : if_ce_i, if_addr_i -> if_data_o, if_ready_o, if_stallreq_o
//   Data    : dm_ce_i, dm_we_i, dm_sel_i, dm_addr_i, dm_data_i -> dm_data_o, dm_ready_o
//   SRAM    : sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_addr_o,
//             sram_wdata_o -> device;  sram_rdata_i <- device
interface sram_arbiter_if #(
  parameter int ADDR_W = 20
);
  logic              if_ce_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_ready_o;
  logic              if_stallreq_o;

  logic              dm_ce_i;
  logic              dm_we_i;
  logic [3:0]        dm_sel_i;
  logic [31:0]       dm_addr_i;
  logic [31:0]       dm_data_i;
  logic [31:0]       dm_data_o;
  logic              dm_ready_o;

  logic              sram_ce_n_o;
  logic              sram_oe_n_o;
  logic              sram_we_n_o;
  logic [3:0]        sram_be_n_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_wdata_o;
  logic [31:0]       sram_rdata_i;

  modport slave (
    input  if_ce_i, if_addr_i,
    output if_data_o, if_ready_o, if_stallreq_o,
    input  dm_ce_i, dm_we_i, dm_sel_i, dm_addr_i, dm_data_i,
    output dm_data_o, dm_ready_o,
    output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_addr_o, sram_wdata_o,
    input  sram_rdata_i
  );

  modport master (
    output if_ce_i, if_addr_i,
    input  if_data_o, if_ready_o, if_stallreq_o,
    output dm_ce_i, dm_we_i, dm_sel_i, dm_addr_i, dm_data_i,
    input  dm_data_o, dm_ready_o,
    input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_addr_o, sram_wdata_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one 32-bit single-port SRAM between the instruction-fetch port and
//   the MEM-stage data port. Each access runs IDLE -> ACCESS (WAIT_CYCLES+1
//   clocks) -> DONE, where the served port gets a one-cycle ready pulse. When
//   both ports request in the same IDLE cycle the port not served last wins.
//   All SRAM pins and ready/data outputs are registered; only the fetch stall
//   request is combinational.
// Ports
//   clk : rising-edge clock
//   rst : asynchronous reset, active-low
//   bus : sram_arbiter_if.slave (fetch port, data port, SRAM pins)
// Parameters
//   ADDR_W      : SRAM word-address width (byte address bits [ADDR_W+1:2])
//   WAIT_CYCLES : extra SRAM cycles per access, must be >= 1
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_dm;   // 1: the previous grant went to the data port
  logic             gnt_dm;    // port owning the access in flight
  logic             lat_we;    // latched write flag of the access in flight
  logic             pick_dm;

  // Data port wins if it is the only requester, or if both request and the
  // fetch port was not the loser last time (reset leaves last_dm=0 -> DM first).
  assign pick_dm = bus.dm_ce_i & (~bus.if_ce_i | ~last_dm);

  assign bus.if_stallreq_o = bus.if_ce_i & ~bus.if_ready_o;

  // Byte-offset bits and address bits beyond the SRAM are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr_i[1:0], bus.if_addr_i[31:ADDR_W+2],
                              bus.dm_addr_i[1:0], bus.dm_addr_i[31:ADDR_W+2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      last_dm          <= 1'b0;
      gnt_dm           <= 1'b0;
      lat_we           <= 1'b0;
      bus.if_ready_o   <= 1'b0;
      bus.dm_ready_o   <= 1'b0;
      bus.if_data_o    <= '0;
      bus.dm_data_o    <= '0;
      bus.sram_ce_n_o  <= 1'b1;
      bus.sram_oe_n_o  <= 1'b1;
      bus.sram_we_n_o  <= 1'b1;
      bus.sram_be_n_o  <= 4'hF;
      bus.sram_addr_o  <= '0;
      bus.sram_wdata_o <= '0;
    end else begin
      // Ready outputs are pulses; only the ACCESS->DONE transition raises one.
      bus.if_ready_o <= 1'b0;
      bus.dm_ready_o <= 1'b0;

      case (state)
        // IDLE: pick a requester and present the first ACCESS cycle's pins.
        S_IDLE: begin
          if (bus.dm_ce_i || bus.if_ce_i) begin
            gnt_dm          <= pick_dm;
            last_dm         <= pick_dm;
            cnt             <= '0;
            state           <= S_ACCESS;
            bus.sram_ce_n_o <= 1'b0;
            if (pick_dm) begin
              lat_we           <= bus.dm_we_i;
              bus.sram_addr_o  <= bus.dm_addr_i[ADDR_W+1:2];
              bus.sram_wdata_o <= bus.dm_data_i;
              bus.sram_be_n_o  <= ~bus.dm_sel_i;
              bus.sram_oe_n_o  <= bus.dm_we_i;
              // WAIT_CYCLES >= 1, so cycle 0 of a write always strobes we_n.
              bus.sram_we_n_o  <= ~bus.dm_we_i;
            end else begin
              lat_we           <= 1'b0;
              bus.sram_addr_o  <= bus.if_addr_i[ADDR_W+1:2];
              bus.sram_be_n_o  <= 4'h0;
              bus.sram_oe_n_o  <= 1'b0;
              bus.sram_we_n_o  <= 1'b1;
            end
          end
        end

        // ACCESS: hold latched request; requester inputs are not looked at.
        S_ACCESS: begin
          if (cnt == CNT_LAST) begin
            state           <= S_DONE;
            bus.sram_ce_n_o <= 1'b1;
            bus.sram_oe_n_o <= 1'b1;
            bus.sram_we_n_o <= 1'b1;
            bus.sram_be_n_o <= 4'hF;
            if (gnt_dm) begin
              bus.dm_ready_o <= 1'b1;
              if (!lat_we) bus.dm_data_o <= bus.sram_rdata_i;
            end else begin
              bus.if_ready_o <= 1'b1;
              bus.if_data_o  <= bus.sram_rdata_i;
            end
          end else begin
            cnt <= CNT_W'(cnt + 1'b1);
            // Release we_n one cycle before the end so data/address stay
            // stable past the write strobe.
            if (lat_we && (CNT_W'(cnt + 1'b1) == CNT_LAST)) bus.sram_we_n_o <= 1'b1;
          end
        end

        // DONE: ready pulse is visible this cycle; pins are idle.
        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Two arbiters (WAIT_CYCLES=1 and 3), each with a behavioural SRAM. Read
//   results are pushed to per-port queues when a request is driven and popped
//   when the port's ready pulse is observed.
module tb_sram_arbiter;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) b1 ();
  sram_arbiter_if #(.ADDR_W(AW)) b3 ();

  sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  // Behavioural SRAMs, with a loader port so only this block writes them.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic        ld_en = 1'b0;
  logic        ld_sel3 = 1'b0;
  logic [7:0]  ld_a = '0;
  logic [31:0] ld_d = '0;

  assign b1.sram_rdata_i = (!b1.sram_ce_n_o && !b1.sram_oe_n_o) ? mem1[b1.sram_addr_o[7:0]] : 32'h0;
  assign b3.sram_rdata_i = (!b3.sram_ce_n_o && !b3.sram_oe_n_o) ? mem3[b3.sram_addr_o[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (ld_en && !ld_sel3) mem1[ld_a] <= ld_d;
    else if (!b1.sram_ce_n_o && !b1.sram_we_n_o)
      for (int i = 0; i < 4; i++)
        if (!b1.sram_be_n_o[i]) mem1[b1.sram_addr_o[7:0]][8*i +: 8] <= b1.sram_wdata_o[8*i +: 8];
    if (ld_en && ld_sel3) mem3[ld_a] <= ld_d;
    else if (!b3.sram_ce_n_o && !b3.sram_we_n_o)
      for (int i = 0; i < 4; i++)
        if (!b3.sram_be_n_o[i]) mem3[b3.sram_addr_o[7:0]][8*i +: 8] <= b3.sram_wdata_o[8*i +: 8];
  end

  // Scoreboards
  logic [31:0] q_if1 [$];
  logic [31:0] q_dm1 [$];
  logic [31:0] q_if3 [$];
  logic [31:0] dm_last1 = 32'h0;

  // Protocol invariants, checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      total++;
      if (!b1.sram_we_n_o && !b1.sram_oe_n_o) begin
        bad++; $display("FAIL u1_we_oe_overlap we_n=%b oe_n=%b required not both 0", b1.sram_we_n_o, b1.sram_oe_n_o);
      end
      total++;
      if (b1.if_ready_o && b1.dm_ready_o) begin
        bad++; $display("FAIL u1_ready_overlap if=%b dm=%b required not both 1", b1.if_ready_o, b1.dm_ready_o);
      end
      total++;
      if (!b3.sram_we_n_o && !b3.sram_oe_n_o) begin
        bad++; $display("FAIL u3_we_oe_overlap we_n=%b oe_n=%b required not both 0", b3.sram_we_n_o, b3.sram_oe_n_o);
      end
    end
  end

  task automatic mem_load(input bit sel3, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_sel3 = sel3; ld_a = a; ld_d = d; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    int rdy;
    repeat (3) @(negedge clk);
    total++;
    if (b1.if_ready_o !== 1'b0 || b1.dm_ready_o !== 1'b0) begin
      bad++; $display("FAIL reset_ready got if=%b dm=%b required 0 0", b1.if_ready_o, b1.dm_ready_o);
    end
    total++;
    if (b1.if_data_o !== 32'h0 || b1.dm_data_o !== 32'h0) begin
      bad++; $display("FAIL reset_data got if=%h dm=%h required 0 0", b1.if_data_o, b1.dm_data_o);
    end
    total++;
    if ({b1.sram_ce_n_o, b1.sram_oe_n_o, b1.sram_we_n_o} !== 3'b111 || b1.sram_be_n_o !== 4'hF) begin
      bad++; $display("FAIL reset_pins got ce/oe/we=%b%b%b be=%h required 111 F",
                      b1.sram_ce_n_o, b1.sram_oe_n_o, b1.sram_we_n_o, b1.sram_be_n_o);
    end
    total++;
    if (b1.sram_addr_o !== '0 || b1.sram_wdata_o !== 32'h0) begin
      bad++; $display("FAIL reset_addr got addr=%h wdata=%h required 0 0", b1.sram_addr_o, b1.sram_wdata_o);
    end
    rst = 1'b1;
    @(negedge clk);
    b1.dm_ce_i = 1'b1; b1.dm_we_i = 1'b1; b1.dm_sel_i = 4'hF;
    b1.dm_addr_i = 32'h20; b1.dm_data_i = 32'h55AA_55AA;
    @(negedge clk);
    total++;
    if (b1.sram_we_n_o !== 1'b0 || b1.sram_ce_n_o !== 1'b0) begin
      bad++; $display("FAIL reset_prewrite got we_n=%b ce_n=%b required 0 0", b1.sram_we_n_o, b1.sram_ce_n_o);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (b1.sram_we_n_o !== 1'b1 || b1.sram_ce_n_o !== 1'b1 || b1.sram_be_n_o !== 4'hF) begin
      bad++; $display("FAIL reset_async got we_n=%b ce_n=%b be=%h required 1 1 F",
                      b1.sram_we_n_o, b1.sram_ce_n_o, b1.sram_be_n_o);
    end
    b1.dm_ce_i = 1'b0; b1.dm_we_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rdy = 0;
    repeat (6) begin
      @(negedge clk);
      if (b1.if_ready_o || b1.dm_ready_o) rdy++;
    end
    total++;
    if (rdy != 0) begin
      bad++; $display("FAIL reset_no_ready got %0d pulses required 0", rdy);
    end
    total++;
    if (mem1[8] !== 32'h0102_0304) begin
      bad++; $display("FAIL reset_no_write got %h required 01020304", mem1[8]);
    end
  endtask

  task automatic test_arbitration();
    bit   port_dm [4];
    int   when [4];
    int   got;
    logic [31:0] exp;
    got = 0;
    b1.dm_ce_i = 1'b1; b1.dm_we_i = 1'b0; b1.dm_sel_i = 4'hF; b1.dm_addr_i = 32'h4;
    b1.if_ce_i = 1'b1; b1.if_addr_i = 32'h8;
    q_dm1.push_back(32'hAAAA_0001); q_dm1.push_back(32'hAAAA_0001);
    q_if1.push_back(32'hBBBB_0002); q_if1.push_back(32'hBBBB_0002);
    dm_last1 = 32'hAAAA_0001;
    for (int k = 1; k <= 40 && got < 4; k++) begin
      @(negedge clk);
      if (b1.dm_ready_o) begin
        port_dm[got] = 1'b1; when[got] = k; got++;
        exp = q_dm1.pop_front();
        total++;
        if (b1.dm_data_o !== exp) begin
          bad++; $display("FAIL arb_dm_data got %h required %h", b1.dm_data_o, exp);
        end
      end else if (b1.if_ready_o) begin
        port_dm[got] = 1'b0; when[got] = k; got++;
        exp = q_if1.pop_front();
        total++;
        if (b1.if_data_o !== exp) begin
          bad++; $display("FAIL arb_if_data got %h required %h", b1.if_data_o, exp);
        end
      end
    end
    b1.dm_ce_i = 1'b0; b1.if_ce_i = 1'b0;
    total++;
    if (got != 4) begin
      bad++; $display("FAIL arb_timeout got %0d grants required 4", got);
    end
    for (int i = 0; i < got; i++) begin
      total++;
      if (port_dm[i] !== (i % 2 == 0)) begin
        bad++; $display("FAIL arb_order grant%0d got dm=%b required dm=%b", i, port_dm[i], (i % 2 == 0));
      end
      total++;
      if (when[i] != 3 + 4 * i) begin
        bad++; $display("FAIL arb_timing grant%0d got cycle %0d required %0d", i, when[i], 3 + 4 * i);
      end
    end
  endtask

  task automatic test_if_read();
    int n, addr_cyc;
    bit stall_ok;
    logic [31:0] exp;
    n = 0; addr_cyc = 0; stall_ok = 1'b1;
    b1.if_addr_i = 32'h0000_0010; b1.if_ce_i = 1'b1;
    q_if1.push_back(32'h2401_0005);
    #1;
    total++;
    if (b1.if_stallreq_o !== 1'b1) begin
      bad++; $display("FAIL if_stall_start got %b required 1", b1.if_stallreq_o);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b1.if_ready_o) begin n = k; break; end
      if (!b1.sram_ce_n_o && b1.sram_addr_o == 20'h4) addr_cyc++;
      if (b1.if_stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL if_latency got %0d required 3", n);
    end
    total++;
    if (addr_cyc != 2) begin
      bad++; $display("FAIL if_addr_cycles got %0d required 2", addr_cyc);
    end
    total++;
    if (!stall_ok || b1.if_stallreq_o !== 1'b0) begin
      bad++; $display("FAIL if_stall got held=%b at_ready=%b required 1 0", stall_ok, b1.if_stallreq_o);
    end
    if (n != 0) begin
      exp = q_if1.pop_front();
      total++;
      if (b1.if_data_o !== exp) begin
        bad++; $display("FAIL if_data got %h required %h", b1.if_data_o, exp);
      end
    end else q_if1.delete();
    b1.if_ce_i = 1'b0;
  endtask

  task automatic test_dm_write();
    int n, we_low, ce_low, pin_bad;
    logic [31:0] exp;
    n = 0; we_low = 0; ce_low = 0; pin_bad = 0;
    b1.dm_ce_i = 1'b1; b1.dm_we_i = 1'b1; b1.dm_sel_i = 4'b0011;
    b1.dm_addr_i = 32'h0000_0104; b1.dm_data_i = 32'hDEAD_BEEF;
    q_dm1.push_back(dm_last1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b1.dm_ready_o) begin n = k; break; end
      if (!b1.sram_we_n_o) we_low++;
      if (!b1.sram_ce_n_o) begin
        ce_low++;
        if (b1.sram_addr_o != 20'h41 || b1.sram_be_n_o != 4'b1100) pin_bad++;
      end
    end
    total++;
    if (n != 3 || we_low != 1 || ce_low != 2) begin
      bad++; $display("FAIL dm_wr_timing got ready=%0d we_low=%0d ce_low=%0d required 3 1 2", n, we_low, ce_low);
    end
    total++;
    if (pin_bad != 0) begin
      bad++; $display("FAIL dm_wr_pins got %0d bad cycles required 0", pin_bad);
    end
    exp = q_dm1.pop_front();
    total++;
    if (b1.dm_data_o !== exp) begin
      bad++; $display("FAIL dm_wr_data_hold got %h required %h", b1.dm_data_o, exp);
    end
    // Read the same word back.
    b1.dm_we_i = 1'b0; b1.dm_sel_i = 4'hF;
    q_dm1.push_back(32'h1122_BEEF);
    dm_last1 = 32'h1122_BEEF;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b1.dm_ready_o) begin n = k; break; end
    end
    b1.dm_ce_i = 1'b0;
    total++;
    if (n != 4) begin
      bad++; $display("FAIL dm_rb_latency got %0d required 4", n);
    end
    exp = q_dm1.pop_front();
    total++;
    if (b1.dm_data_o !== exp) begin
      bad++; $display("FAIL dm_readback got %h required %h", b1.dm_data_o, exp);
    end
    total++;
    if (mem1[8'h41] !== 32'h1122_BEEF) begin
      bad++; $display("FAIL dm_mem_word got %h required 1122beef", mem1[8'h41]);
    end
  endtask

  task automatic test_ce_drop();
    int rdy, addr_bad;
    logic [31:0] exp;
    rdy = 0; addr_bad = 0;
    b1.dm_ce_i = 1'b1; b1.dm_we_i = 1'b0; b1.dm_sel_i = 4'hF; b1.dm_addr_i = 32'h0000_00C0;
    q_dm1.push_back(32'hCCCC_0030);
    dm_last1 = 32'hCCCC_0030;
    @(negedge clk);
    b1.dm_ce_i = 1'b0; b1.dm_addr_i = 32'h0000_00C4;
    repeat (10) begin
      if (!b1.sram_ce_n_o && b1.sram_addr_o != 20'h30) addr_bad++;
      if (b1.dm_ready_o) begin
        rdy++;
        exp = q_dm1.pop_front();
        total++;
        if (b1.dm_data_o !== exp) begin
          bad++; $display("FAIL ce_drop_data got %h required %h", b1.dm_data_o, exp);
        end
      end
      @(negedge clk);
    end
    total++;
    if (rdy != 1) begin
      bad++; $display("FAIL ce_drop_pulses got %0d required 1", rdy);
    end
    total++;
    if (addr_bad != 0) begin
      bad++; $display("FAIL ce_drop_addr got %0d bad cycles required 0", addr_bad);
    end
  endtask

  task automatic test_back_to_back();
    int when [3];
    int got, oe_cnt;
    logic [31:0] exp;
    got = 0; oe_cnt = 0;
    b3.if_addr_i = 32'h0000_0014; b3.if_ce_i = 1'b1;
    q_if3.push_back(32'h3333_0005);
    for (int k = 1; k <= 60 && got < 3; k++) begin
      @(negedge clk);
      if (!b3.sram_oe_n_o) oe_cnt++;
      if (b3.if_ready_o) begin
        when[got] = k;
        total++;
        if (oe_cnt != 4) begin
          bad++; $display("FAIL b2b_oe_cycles access%0d got %0d required 4", got, oe_cnt);
        end
        oe_cnt = 0;
        exp = q_if3.pop_front();
        total++;
        if (b3.if_data_o !== exp) begin
          bad++; $display("FAIL b2b_data access%0d got %h required %h", got, b3.if_data_o, exp);
        end
        got++;
        if (got < 3) begin
          b3.if_addr_i = b3.if_addr_i + 32'd4;
          q_if3.push_back(32'h3333_0005 + 32'(got));
        end else b3.if_ce_i = 1'b0;
      end
    end
    b3.if_ce_i = 1'b0;
    total++;
    if (got != 3) begin
      bad++; $display("FAIL b2b_timeout got %0d reads required 3", got);
    end else begin
      total++;
      if (when[0] != 5 || when[1] - when[0] != 6 || when[2] - when[1] != 6) begin
        bad++; $display("FAIL b2b_period got %0d %0d %0d required 5 11 17", when[0], when[1], when[2]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    b1.if_ce_i = 1'b0; b1.if_addr_i = '0;
    b1.dm_ce_i = 1'b0; b1.dm_we_i = 1'b0; b1.dm_sel_i = '0; b1.dm_addr_i = '0; b1.dm_data_i = '0;
    b3.if_ce_i = 1'b0; b3.if_addr_i = '0;
    b3.dm_ce_i = 1'b0; b3.dm_we_i = 1'b0; b3.dm_sel_i = '0; b3.dm_addr_i = '0; b3.dm_data_i = '0;
    mem_load(1'b0, 8'h04, 32'h2401_0005);
    mem_load(1'b0, 8'h41, 32'h1122_3344);
    mem_load(1'b0, 8'h01, 32'hAAAA_0001);
    mem_load(1'b0, 8'h02, 32'hBBBB_0002);
    mem_load(1'b0, 8'h08, 32'h0102_0304);
    mem_load(1'b0, 8'h30, 32'hCCCC_0030);
    mem_load(1'b0, 8'h31, 32'hDDDD_0031);
    mem_load(1'b1, 8'h05, 32'h3333_0005);
    mem_load(1'b1, 8'h06, 32'h3333_0006);
    mem_load(1'b1, 8'h07, 32'h3333_0007);
    test_reset();
    test_arbitration();
    repeat (2) @(negedge clk);
    test_if_read();
    repeat (2) @(negedge clk);
    test_dm_write();
    repeat (2) @(negedge clk);
    test_ce_drop();
    repeat (2) @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
